// File: rtl/priority_engine.sv
// Programmable interrupt priority engine: edge/level request capture, rotating priority,
// nested in-service tracking and a two-acknowledge vector handshake.
module priority_engine #(
    parameter int NUM_IRQ = 8,
    parameter int LVL_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               level_mode,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               rotate_mode,
    input  logic               auto_eoi,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [LVL_W-1:0]   eoi_level,
    input  logic               rot_set_valid,
    input  logic [LVL_W-1:0]   rot_set_level,
    input  logic               ack,
    output logic               int_out,
    output logic               vector_valid,
    output logic [LVL_W-1:0]   vector,
    output logic               spurious,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK1, WAIT_ACK2} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [LVL_W-1:0]   lp;
    logic [LVL_W-1:0]   lat_level;
    logic               lat_spur;

    int                 isr_rank;
    int                 isr_eoi_rank;
    int                 cand_rank;
    logic               eoi_hit;
    logic [LVL_W-1:0]   eoi_lvl_eff;
    logic [NUM_IRQ-1:0] isr_eoi;
    logic [LVL_W-1:0]   cand_lvl;
    logic               eligible;
    logic               take;
    logic               auto_clr;
    logic [NUM_IRQ-1:0] isr_next;
    logic [NUM_IRQ-1:0] irr_next;
    logic [LVL_W-1:0]   lp_next;

    // Rank 1 is the level just above lp, rank NUM_IRQ is lp itself; 0 means no bit set.
    function automatic int top_rank(input logic [NUM_IRQ-1:0] v, input logic [LVL_W-1:0] p);
        int r;
        int pos;
        r = 0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            pos = ((j - int'(p) - 1 + 2 * NUM_IRQ) % NUM_IRQ) + 1;
            if (v[j] && (r == 0 || pos < r)) r = pos;
        end
        return r;
    endfunction

    function automatic logic [LVL_W-1:0] rank_to_level(input int r, input logic [LVL_W-1:0] p);
        int t;
        t = (int'(p) + r) % NUM_IRQ;
        return LVL_W'(t);
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [LVL_W-1:0] l);
        return {{(NUM_IRQ-1){1'b0}}, 1'b1} << l;
    endfunction

    function automatic logic in_range(input logic [LVL_W-1:0] l);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (l == LVL_W'(k)) ok = 1'b1;
        end
        return ok;
    endfunction

    // EOI is folded into isr before the eligibility check so an EOI and a first ack
    // arriving together both take effect.
    always_comb begin
        isr_rank    = top_rank(isr, lp);
        eoi_hit     = 1'b0;
        eoi_lvl_eff = rank_to_level(isr_rank, lp);
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (in_range(eoi_level)) begin
                    eoi_hit     = 1'b1;
                    eoi_lvl_eff = eoi_level;
                end
            end else if (isr_rank != 0) begin
                eoi_hit = 1'b1;
            end
        end
        isr_eoi      = eoi_hit ? (isr & ~onehot(eoi_lvl_eff)) : isr;
        isr_eoi_rank = top_rank(isr_eoi, lp);
        cand_rank    = top_rank(irr & ~imr, lp);
        cand_lvl     = rank_to_level(cand_rank, lp);
        eligible     = (cand_rank != 0) && (isr_eoi_rank == 0 || cand_rank < isr_eoi_rank);

        take     = (state == WAIT_ACK1) && ack && eligible;
        auto_clr = (state == WAIT_ACK2) && ack && auto_eoi && !lat_spur;

        isr_next = isr_eoi;
        if (take)     isr_next = isr_next | onehot(cand_lvl);
        if (auto_clr) isr_next = isr_next & ~onehot(lat_level);

        if (level_mode) irr_next = irq_in;
        else            irr_next = (irr & ~(take ? onehot(cand_lvl) : '0)) | (irq_in & ~irq_prev);

        // Explicit pointer load outranks EOI rotation, which outranks auto-EOI rotation.
        lp_next = lp;
        if (auto_clr && rotate_mode)                 lp_next = lat_level;
        if (eoi_hit && rotate_mode)                  lp_next = eoi_lvl_eff;
        if (rot_set_valid && in_range(rot_set_level)) lp_next = rot_set_level;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            irq_prev     <= '0;
            irr          <= '0;
            isr          <= '0;
            lp           <= LVL_W'(NUM_IRQ - 1);
            int_out      <= 1'b0;
            vector_valid <= 1'b0;
            vector       <= '0;
            spurious     <= 1'b0;
            lat_level    <= '0;
            lat_spur     <= 1'b0;
        end else begin
            irq_prev     <= irq_in;
            irr          <= irr_next;
            isr          <= isr_next;
            lp           <= lp_next;
            vector_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (eligible) begin
                        state   <= WAIT_ACK1;
                        int_out <= 1'b1;
                    end
                end
                WAIT_ACK1: begin
                    if (ack) begin
                        int_out <= 1'b0;
                        state   <= WAIT_ACK2;
                        if (eligible) begin
                            lat_level <= cand_lvl;
                            lat_spur  <= 1'b0;
                        end else begin
                            lat_level <= LVL_W'(NUM_IRQ - 1);
                            lat_spur  <= 1'b1;
                        end
                    end
                end
                WAIT_ACK2: begin
                    if (ack) begin
                        vector_valid <= 1'b1;
                        vector       <= lat_level;
                        spurious     <= lat_spur;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
